i2c_eeprom_arbiter: RTL and testbench
=====================================

I2C_EEPROM_ARBITER -- requirements
Module: i2c_eeprom_arbiter

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the EEPROM 7-bit device address.
REQ-002 SHALL have parameter CLK_RATE, default 3'd6, meaning the controller clock-rate code (781 kHz at 100 MHz).
REQ-003 SHALL have parameter TWR_CYCLES, default 500000, meaning the EEPROM write-cycle wait in i_clk cycles (5 ms at 100 MHz).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning the transaction watchdog limit.
REQ-005 SHALL provide the ports: i_clk input 1, the single clock; i_rst input 1, asynchronous, active-high reset.
REQ-006 SHALL provide the requester ports: i_req input 2, per-requester request; i_we input 2, 1 = write, 0 = read; i_addr0 and i_addr1 input 16, EEPROM byte address; i_wdata0 and i_wdata1 input 32, write data.
REQ-007 SHALL provide the requester response ports: o_done output 2, one-hot completion pulse; o_err output 1, error flag valid with o_done; o_rdata output 32, read data; o_busy output 1, transaction in progress.
REQ-008 SHALL provide the controller-side ports: o_i2c_ctrl output 32; o_i2c_dev_addr output 7; o_i2c_reg_addr output 16; o_i2c_w_data output 32; i_i2c_status input 32; i_i2c_rd_data input 32, ordered {byte1, byte2, byte3, byte4}.

Function
REQ-009 SHALL implement these states: IDLE, ARB, LAUNCH, BUSY, WAIT_IDLE, WR_WAIT, DONE.
REQ-010 SHALL sample i_req only in IDLE; if any bit is set, the next state is ARB.
REQ-011 SHALL arbitrate round-robin in ARB: the requester not granted last wins when both request; after reset, requester 0 wins.
REQ-012 SHALL, in ARB, latch the winner's operands, drive o_i2c_dev_addr = DEV_ADDR, and set o_busy = 1 (o_busy stays 1 until IDLE is re-entered).
REQ-013 SHALL, in LAUNCH, drive o_i2c_ctrl as: [0] = 1; [3:1] = 0 for a write or 1 for a read; [6:4] = CLK_RATE; all other bits 0. Enable stays 1 until finish or error.
REQ-014 SHALL, in BUSY, set a "left" flag when i_i2c_status[9:2] != 0, and detect finish as a rising edge of i_i2c_status[1].
REQ-015 SHALL, on finish: clear enable, capture o_rdata <= i_i2c_rd_data if the transaction is a read, and go to WAIT_IDLE.
REQ-016 SHALL treat "left" = 1 with status[9:2] == 0 and no finish seen as a NACK: set the error flag, clear enable, and go to DONE.
REQ-017 SHALL, in WAIT_IDLE, wait for i_i2c_status[9:2] == 0, then go to WR_WAIT for a write or DONE for a read.
REQ-018 SHALL, in WR_WAIT, count TWR_CYCLES i_clk cycles and then go to DONE; an errored transaction skips WR_WAIT.
REQ-019 SHALL, in DONE, pulse o_done[granted] for exactly one cycle with o_err valid, update the round-robin pointer, and return to IDLE.
REQ-020 SHALL hold o_rdata until the next successful read, and SHALL leave o_rdata unchanged on a write or an error.
REQ-021 SHALL treat an i_req still high in the cycle after o_done as a new request.
REQ-022 SHALL require requesters to keep operands stable only until o_busy rises; changes after that point are ignored.

Reset
REQ-023 SHALL, on i_rst asserted at any time (including mid-transaction), immediately force: state IDLE; o_i2c_ctrl = 0; o_done = 0; o_err = 0; o_busy = 0; o_rdata = 0; o_i2c_reg_addr = 0; o_i2c_w_data = 0; o_i2c_dev_addr = DEV_ADDR; round-robin pointer to requester 0; all counters 0.
REQ-024 SHALL release reset synchronously with respect to the next i_clk edge behaviour and perform no transaction until i_req is sampled in IDLE.

Configuration
REQ-025 SHALL, with macro I2C_ARB_TIMEOUT_EN defined, count cycles spent in LAUNCH, BUSY and WAIT_IDLE; on reaching TIMEOUT_CYCLES it SHALL set the error flag, clear enable, and go to DONE.
REQ-026 SHALL, without I2C_ARB_TIMEOUT_EN, omit the watchdog counter, so that BUSY and WAIT_IDLE wait indefinitely.

Verification
REQ-027 SHALL cover a single read: i_req = 01, i_we = 00, i_addr0 = 16'h0010; controller model returns 32'hDEADBEEF -> o_i2c_ctrl[3:0] = 4'b0011, o_rdata = 32'hDEADBEEF, o_done = 01, o_err = 0.
REQ-028 SHALL cover a single write: i_req = 10, i_we = 10, i_wdata1 = 32'h12345678 -> o_i2c_w_data = 32'h12345678, o_i2c_ctrl[3:0] = 4'b0001, o_done = 10 no earlier than TWR_CYCLES after finish.
REQ-029 SHALL cover contention: i_req = 11 held through two transactions -> grants occur in order requester 0 then requester 1, each with one o_done pulse.
REQ-030 SHALL cover a NACK: the model's state goes 1 -> 31 -> 32 -> 0 with no finish -> o_err = 1 with o_done, no WR_WAIT, and o_rdata unchanged.
REQ-031 SHALL cover reset mid-BUSY: i_rst pulsed -> o_i2c_ctrl = 0 and o_busy = 0 immediately, and the next request completes normally.
REQ-032 SHALL cover the watchdog with I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 100, with a stuck status -> o_err = 1 with o_done 100 cycles after LAUNCH.

Source files
------------

// File: rtl/i2c_eeprom_arbiter_if.sv
// Requester / controller bundle for i2c_eeprom_arbiter.
//   slave  : arbiter view (takes requests, drives the I2C controller)
//   master : requester/controller side view (testbench, SoC glue)
// Requester side : i_req, i_we, i_addr0/1, i_wdata0/1 -> o_done, o_err, o_rdata, o_busy
// Controller side: o_i2c_ctrl, o_i2c_dev_addr, o_i2c_reg_addr, o_i2c_w_data
//                  <- i_i2c_status, i_i2c_rd_data ({byte1,byte2,byte3,byte4})
interface i2c_eeprom_arbiter_if;
  logic [1:0]  i_req;
  logic [1:0]  i_we;
  logic [15:0] i_addr0;
  logic [15:0] i_addr1;
  logic [31:0] i_wdata0;
  logic [31:0] i_wdata1;
  logic [1:0]  o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic [31:0] o_i2c_ctrl;
  logic [6:0]  o_i2c_dev_addr;
  logic [15:0] o_i2c_reg_addr;
  logic [31:0] o_i2c_w_data;
  logic [31:0] i_i2c_status;
  logic [31:0] i_i2c_rd_data;

  modport slave (
    input  i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_i2c_status, i_i2c_rd_data,
    output o_done, o_err, o_rdata, o_busy,
           o_i2c_ctrl, o_i2c_dev_addr, o_i2c_reg_addr, o_i2c_w_data
  );

  modport master (
    output i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_i2c_status, i_i2c_rd_data,
    input  o_done, o_err, o_rdata, o_busy,
           o_i2c_ctrl, o_i2c_dev_addr, o_i2c_reg_addr, o_i2c_w_data
  );
endinterface

// File: rtl/i2c_eeprom_arbiter.sv
// Two-requester round-robin arbiter in front of an I2C EEPROM controller.
// A granted request is launched on the controller (enable + read/write opcode +
// clock-rate code), completion is taken from the rising edge of status[1], and
// writes additionally wait out the EEPROM internal write cycle (TWR_CYCLES).
// A controller that goes busy then idle without finishing is reported as NACK.
//
// Ports: i_clk, i_rst (async, active high), bus (i2c_eeprom_arbiter_if.slave).
// Parameters: DEV_ADDR, CLK_RATE, TWR_CYCLES (>=1), TIMEOUT_CYCLES.
// Optional: define I2C_ARB_TIMEOUT_EN to add a watchdog over LAUNCH/BUSY/WAIT_IDLE
// that errors the transaction after TIMEOUT_CYCLES cycles.
module i2c_eeprom_arbiter #(
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter logic [2:0]  CLK_RATE       = 3'd6,
  parameter int unsigned TWR_CYCLES     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic                 i_clk,
  input logic                 i_rst,
  i2c_eeprom_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, BUSY, WAIT_IDLE, WR_WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]  req_q;      // requests sampled in IDLE; ARB works on this copy
  logic        gnt;        // requester currently being served
  logic        rr;         // requester preferred on the next contention
  logic        we_q;
  logic        left;       // controller has been seen active in this transaction
  logic        st1_q;      // previous status[1], for finish edge detection
  logic        err;
  logic        busy;
  logic [31:0] ctrl;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [31:0] wcnt;
  logic [15:0] addr;

  logic win, grab, finish, abort, ctl_active, fin_edge;

  assign ctl_active = |bus.i_i2c_status[9:2];
  assign fin_edge   = bus.i_i2c_status[1] & ~st1_q;
  // both requesting -> pointer decides, otherwise the only requester wins
  assign win        = (req_q == 2'b11) ? rr : ~req_q[0];

  logic unused_status;
  assign unused_status = &{1'b0, bus.i_i2c_status[31:10], bus.i_i2c_status[0]};

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        in_wd, tmo;
  assign in_wd = (state == LAUNCH) || (state == BUSY) || (state == WAIT_IDLE);
  assign tmo   = in_wd && (tcnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tcnt <= '0;
    else       tcnt <= in_wd ? tcnt + 32'd1 : '0;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grab     = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE:      if (|bus.i_req) state_nx = ARB;
      ARB: begin
        grab     = 1'b1;
        state_nx = LAUNCH;
      end
      LAUNCH:    state_nx = BUSY;
      BUSY: begin
        if (fin_edge) begin
          finish   = 1'b1;
          state_nx = WAIT_IDLE;
        end else if (left && !ctl_active) begin
          // went active and came back idle without finishing: NACK
          abort    = 1'b1;
          state_nx = DONE;
        end
      end
      WAIT_IDLE: if (!ctl_active) state_nx = we_q ? WR_WAIT : DONE;
      WR_WAIT:   if (wcnt == TWR_CYCLES - 32'd1) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    if (tmo) begin
      finish   = 1'b0;
      abort    = 1'b1;
      state_nx = DONE;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_q <= '0;
      gnt   <= 1'b0;
      rr    <= 1'b0;
      we_q  <= 1'b0;
      left  <= 1'b0;
      st1_q <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      ctrl  <= '0;
      rdata <= '0;
      wdata <= '0;
      addr  <= '0;
      wcnt  <= '0;
    end else begin
      st1_q <= bus.i_i2c_status[1];
      wcnt  <= (state == WR_WAIT) ? wcnt + 32'd1 : '0;
      if (state == IDLE) req_q <= bus.i_req;
      if (grab) begin
        // operands are captured on the same edge busy rises, so the
        // requester may change them from then on
        gnt   <= win;
        we_q  <= bus.i_we[win];
        addr  <= win ? bus.i_addr1  : bus.i_addr0;
        wdata <= win ? bus.i_wdata1 : bus.i_wdata0;
        left  <= 1'b0;
        err   <= 1'b0;
        busy  <= 1'b1;
        ctrl  <= {25'd0, CLK_RATE, (bus.i_we[win] ? 3'd0 : 3'd1), 1'b1};
      end
      if (state == BUSY && ctl_active) left <= 1'b1;
      if (finish) begin
        ctrl <= '0;
        if (!we_q) rdata <= bus.i_i2c_rd_data;
      end
      if (abort) begin
        ctrl <= '0;
        err  <= 1'b1;
      end
      if (state == DONE) begin
        rr   <= ~gnt;
        busy <= 1'b0;
      end
    end
  end

  assign bus.o_i2c_ctrl     = ctrl;
  assign bus.o_i2c_dev_addr = DEV_ADDR;
  assign bus.o_i2c_reg_addr = addr;
  assign bus.o_i2c_w_data   = wdata;
  assign bus.o_rdata        = rdata;
  assign bus.o_busy         = busy;
  assign bus.o_done         = (state == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_err          = (state == DONE) & err;

endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// Bench for i2c_eeprom_arbiter: directed transactions against a scripted
// controller model; a queue of expected completions is checked every cycle.
module tb_i2c_eeprom_arbiter;
  localparam int unsigned TWR = 20;
  localparam int unsigned TMO = 100;
  localparam int M_NORM  = 0;
  localparam int M_NACK  = 1;
  localparam int M_STUCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_eeprom_arbiter_if bus();

  i2c_eeprom_arbiter #(
    .DEV_ADDR(7'h50), .CLK_RATE(3'd6), .TWR_CYCLES(TWR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic        twr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, launch_cyc = 0, fin_cyc = 0;
  int mode = M_NORM, ph = 0, n = 0;
  logic [31:0] hold = '0;
  logic [31:0] seen_ctrl, seen_wdata;
  logic [15:0] seen_addr;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic e, input logic [31:0] r, input logic t);
    exp_t x;
    x.done = d; x.err = e; x.rdata = r; x.twr = t;
    q.push_back(x);
    n++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_launch(input string nm);
    int k = 0;
    while (bus.o_busy && k < 50) begin tick(); k++; end
    while (!bus.o_busy && k < 100) begin tick(); k++; end
    check(nm, 64'(bus.o_busy), 64'(1));
  endtask

  task automatic wait_done(input int target, input string nm);
    int k = 0;
    while (done_cnt < target && k < 400) begin tick(); k++; end
    check(nm, 64'(done_cnt >= target), 64'(1));
  endtask

  // controller status script: state in [9:2], finish in [1]
  function automatic logic [31:0] stat(input int m, input int i);
    if (m == M_STUCK) return 32'd7 << 2;
    if (m == M_NACK) begin
      case (i)
        0: return 32'd1 << 2;
        1: return 32'd31 << 2;
        2: return 32'd32 << 2;
        default: return 32'd0;
      endcase
    end
    case (i)
      0: return 32'd1 << 2;
      1: return 32'd2 << 2;
      2: return 32'd3 << 2;
      3: return (32'd4 << 2) | 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // controller model
  always @(negedge clk) begin
    if (rst) begin
      ph = 0;
      bus.i_i2c_status = '0;
    end else if (ph == 0) begin
      if (bus.o_i2c_ctrl[0]) begin
        seen_ctrl  = bus.o_i2c_ctrl;
        seen_addr  = bus.o_i2c_reg_addr;
        seen_wdata = bus.o_i2c_w_data;
        launch_cyc = cyc;
        bus.i_i2c_status = stat(mode, 0);
        ph = 1;
      end
    end else if (mode == M_STUCK) begin
      if (!bus.o_i2c_ctrl[0]) begin
        ph = 0;
        bus.i_i2c_status = '0;
      end
    end else begin
      bus.i_i2c_status = stat(mode, ph);
      if (bus.i_i2c_status[1]) fin_cyc = cyc;
      ph = (bus.i_i2c_status == 32'd0) ? 0 : ph + 1;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      check("dev_addr", 64'(bus.o_i2c_dev_addr), 64'(7'h50));
      if (bus.o_done != 2'b00) begin
        done_cnt++;
        done_cyc = cyc;
        if (q.size() == 0) check("spurious_done", 64'(bus.o_done), 64'(0));
        else begin
          mon_e = q.pop_front();
          check("done", 64'(bus.o_done), 64'(mon_e.done));
          check("err", 64'(bus.o_err), 64'(mon_e.err));
          check("rdata", 64'(bus.o_rdata), 64'(mon_e.rdata));
          if (mon_e.twr)
            check("twr_gap", 64'((cyc - fin_cyc >= int'(TWR)) && (cyc - fin_cyc <= int'(TWR) + 4)), 64'(1));
          hold = mon_e.rdata;
        end
      end else if (!bus.o_busy) begin
        check("err_idle", 64'(bus.o_err), 64'(0));
        check("rdata_hold", 64'(bus.o_rdata), 64'(hold));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bus.i_req = '0; bus.i_we = '0; bus.i_addr0 = '0; bus.i_addr1 = '0;
    bus.i_wdata0 = '0; bus.i_wdata1 = '0; bus.i_i2c_rd_data = '0;
    repeat (3) tick();
    check("rst_ctrl",  64'(bus.o_i2c_ctrl),     64'(0));
    check("rst_done",  64'(bus.o_done),         64'(0));
    check("rst_err",   64'(bus.o_err),          64'(0));
    check("rst_busy",  64'(bus.o_busy),         64'(0));
    check("rst_rdata", 64'(bus.o_rdata),        64'(0));
    check("rst_addr",  64'(bus.o_i2c_reg_addr), 64'(0));
    check("rst_wdata", 64'(bus.o_i2c_w_data),   64'(0));
    check("rst_dev",   64'(bus.o_i2c_dev_addr), 64'(7'h50));
    rst = 1'b0;

    // single read from requester 0; operands changed after busy must not matter
    mode = M_NORM;
    bus.i_i2c_rd_data = 32'hDEADBEEF;
    bus.i_addr0 = 16'h0010; bus.i_we = 2'b00; bus.i_req = 2'b01;
    push(2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_launch("rd_launch");
    bus.i_req = 2'b00; bus.i_addr0 = 16'hFFFF;
    wait_done(n, "rd_done");
    check("rd_ctrl_op",  64'(seen_ctrl[3:0]), 64'(4'b0011));
    check("rd_ctrl",     64'(seen_ctrl),      64'(32'h0000_0063));
    check("rd_addr",     64'(seen_addr),      64'(16'h0010));
    check("rd_addr_hold",64'(bus.o_i2c_reg_addr), 64'(16'h0010));
    tick();
    check("rd_busy_low", 64'(bus.o_busy), 64'(0));

    // single write from requester 1; read data bus must not be captured
    bus.i_i2c_rd_data = 32'h0BADF00D;
    bus.i_we = 2'b10; bus.i_addr1 = 16'h0200; bus.i_wdata1 = 32'h12345678; bus.i_req = 2'b10;
    push(2'b10, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_launch("wr_launch");
    bus.i_req = 2'b00; bus.i_wdata1 = 32'h0;
    wait_done(n, "wr_done");
    check("wr_wdata",   64'(seen_wdata),     64'(32'h12345678));
    check("wr_ctrl_op", 64'(seen_ctrl[3:0]), 64'(4'b0001));
    check("wr_ctrl",    64'(seen_ctrl),      64'(32'h0000_0061));
    check("wr_addr",    64'(seen_addr),      64'(16'h0200));

    // contention: both held, requester 0 (read) then requester 1 (write)
    bus.i_i2c_rd_data = 32'h01234567;
    bus.i_we = 2'b10; bus.i_addr0 = 16'h0011; bus.i_addr1 = 16'h0300;
    bus.i_wdata1 = 32'hCAFEF00D; bus.i_req = 2'b11;
    push(2'b01, 1'b0, 32'h01234567, 1'b0);
    push(2'b10, 1'b0, 32'h01234567, 1'b1);
    wait_done(n - 1, "ct_first_done");
    check("ct_first_addr", 64'(seen_addr), 64'(16'h0011));
    wait_launch("ct_second_launch");
    bus.i_req = 2'b00;
    wait_done(n, "ct_second_done");
    check("ct_second_addr",  64'(seen_addr),  64'(16'h0300));
    check("ct_second_wdata", 64'(seen_wdata), 64'(32'hCAFEF00D));

    // NACK on a write: error, no write-cycle wait, read data untouched
    mode = M_NACK;
    bus.i_i2c_rd_data = 32'hBAD0BAD0;
    bus.i_we = 2'b01; bus.i_addr0 = 16'h0020; bus.i_wdata0 = 32'h11111111; bus.i_req = 2'b01;
    push(2'b01, 1'b1, 32'h01234567, 1'b0);
    wait_launch("nack_launch");
    bus.i_req = 2'b00;
    wait_done(n, "nack_done");
    check("nack_no_twr", 64'(done_cyc - launch_cyc <= 6), 64'(1));

`ifdef I2C_ARB_TIMEOUT_EN
    // watchdog: controller never leaves busy
    mode = M_STUCK;
    bus.i_we = 2'b00; bus.i_req = 2'b01;
    push(2'b01, 1'b1, 32'h01234567, 1'b0);
    wait_launch("wd_launch");
    bus.i_req = 2'b00;
    wait_done(n, "wd_done");
    check("wd_cycles", 64'(done_cyc - launch_cyc), 64'(100));
`endif

    // reset in the middle of a stuck transaction from requester 1
    mode = M_STUCK;
    bus.i_we = 2'b00; bus.i_req = 2'b10;
    wait_launch("stk_launch");
    bus.i_req = 2'b00;
    repeat (30) tick();
    check("stk_busy", 64'(bus.o_busy), 64'(1));
    check("stk_no_done", 64'(done_cnt), 64'(n));
    @(negedge clk);
    #2 rst = 1'b1;
    hold = '0;
    #1;
    check("mrst_ctrl",  64'(bus.o_i2c_ctrl), 64'(0));
    check("mrst_busy",  64'(bus.o_busy),     64'(0));
    check("mrst_done",  64'(bus.o_done),     64'(0));
    check("mrst_rdata", 64'(bus.o_rdata),    64'(0));
    @(negedge clk);
    rst = 1'b0;
    mode = M_NORM;

    // next request completes normally; pointer is back at requester 0
    bus.i_i2c_rd_data = 32'h55AA55AA;
    bus.i_we = 2'b00; bus.i_addr0 = 16'h0040; bus.i_addr1 = 16'h0050; bus.i_req = 2'b11;
    push(2'b01, 1'b0, 32'h55AA55AA, 1'b0);
    wait_launch("post_launch");
    bus.i_req = 2'b00;
    wait_done(n, "post_done");
    check("post_addr", 64'(seen_addr), 64'(16'h0040));
    repeat (5) tick();
    check("queue_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
